// File: rtl/anita4_l1_coinc_if.sv
// anita4_l1_coinc_if: synchronizer inputs, controls, trigger and scaler outputs of the L1 coincidence stage
interface anita4_l1_coinc_if #(parameter int SCALER_W = 16);
  logic [2:0] LCP_SYNC;
  logic [2:0] RCP_SYNC;
  logic MASK_L;
  logic MASK_R;
  logic [3:0] WINDOW;
  logic SCALER_SNAP;
  logic L1_TRIG;
  logic [1:0] L1_POL;
  logic LATCH_CLR_L;
  logic LATCH_CLR_R;
  logic [SCALER_W-1:0] SCALER_L;
  logic [SCALER_W-1:0] SCALER_R;
  logic [SCALER_W-1:0] SCALER_COINC;
  modport master (
    output LCP_SYNC, RCP_SYNC, MASK_L, MASK_R, WINDOW, SCALER_SNAP,
    input L1_TRIG, L1_POL, LATCH_CLR_L, LATCH_CLR_R, SCALER_L, SCALER_R, SCALER_COINC
  );
  modport slave (
    input LCP_SYNC, RCP_SYNC, MASK_L, MASK_R, WINDOW, SCALER_SNAP,
    output L1_TRIG, L1_POL, LATCH_CLR_L, LATCH_CLR_R, SCALER_L, SCALER_R, SCALER_COINC
  );
endinterface

// File: rtl/anita4_l1_coinc.sv
// anita4_l1_coinc: per-phi-sector LCP/RCP coincidence trigger with latch re-arm and saturating scalers
module anita4_l1_coinc #(
  parameter int HOLDOFF  = 4,
  parameter int SCALER_W = 16
) (
  input logic CLK,
  input logic CLR_B,
  anita4_l1_coinc_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, FIRE, CLEAR} state_t;
  localparam logic [3:0] HO = 4'(HOLDOFF);
  state_t state_q;
  logic [3:0] cnt_q;
  logic [1:0] first_q, pol_q;
  logic trig_q, clr_l_q, clr_r_q;
  logic [SCALER_W-1:0] cnt_l_q, cnt_r_q, cnt_c_q, out_l_q, out_r_q, out_c_q;
  logic new_l, new_r, acc_l, acc_r, acc_c, unused;
  assign unused = ^{bus.LCP_SYNC[0], bus.RCP_SYNC[0]};
  assign new_l = bus.LCP_SYNC[1] & ~bus.LCP_SYNC[2] & ~bus.MASK_L;
  assign new_r = bus.RCP_SYNC[1] & ~bus.RCP_SYNC[2] & ~bus.MASK_R;
  // while waiting, only the opposite polarization is accepted
  assign acc_l = new_l & (state_q == IDLE || (state_q == WAIT && first_q == 2'b10));
  assign acc_r = new_r & (state_q == IDLE || (state_q == WAIT && first_q == 2'b01));
  assign acc_c = state_q == FIRE;
  always_ff @(posedge CLK or negedge CLR_B) begin
    if (!CLR_B) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      first_q <= '0;
      pol_q   <= '0;
      trig_q  <= 1'b0;
      clr_l_q <= 1'b1;
      clr_r_q <= 1'b1;
    end else begin
      trig_q  <= 1'b0;
      clr_l_q <= bus.MASK_L;
      clr_r_q <= bus.MASK_R;
      case (state_q)
        IDLE:
          if (new_l & new_r) begin
            state_q <= FIRE;
            pol_q   <= 2'b11;
            trig_q  <= 1'b1;
          end else if (new_l | new_r) begin
            first_q <= {new_r, new_l};
            if (bus.WINDOW != 4'd0) begin
              state_q <= WAIT;
              cnt_q   <= bus.WINDOW;
            end else begin
              state_q <= CLEAR;
              cnt_q   <= HO;
              clr_l_q <= 1'b1;
              clr_r_q <= 1'b1;
            end
          end
        WAIT:
          if (acc_l | acc_r) begin
            state_q <= FIRE;
            pol_q   <= first_q;
            trig_q  <= 1'b1;
          end else if (cnt_q == 4'd1) begin
            state_q <= CLEAR;
            cnt_q   <= HO;
            clr_l_q <= 1'b1;
            clr_r_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        FIRE: begin
          state_q <= CLEAR;
          cnt_q   <= HO;
          clr_l_q <= 1'b1;
          clr_r_q <= 1'b1;
        end
        default:
          if (cnt_q == 4'd1) begin
            state_q <= IDLE;
          end else begin
            cnt_q   <= cnt_q - 4'd1;
            clr_l_q <= 1'b1;
            clr_r_q <= 1'b1;
          end
      endcase
    end
  end
  // a snap reports the old count; a same-cycle event opens the new interval at 1
  always_ff @(posedge CLK or negedge CLR_B) begin
    if (!CLR_B) begin
      cnt_l_q <= '0;
      cnt_r_q <= '0;
      cnt_c_q <= '0;
      out_l_q <= '0;
      out_r_q <= '0;
      out_c_q <= '0;
    end else begin
      cnt_l_q <= bus.SCALER_SNAP ? SCALER_W'(acc_l) : cnt_l_q + SCALER_W'(acc_l & ~(&cnt_l_q));
      cnt_r_q <= bus.SCALER_SNAP ? SCALER_W'(acc_r) : cnt_r_q + SCALER_W'(acc_r & ~(&cnt_r_q));
      cnt_c_q <= bus.SCALER_SNAP ? SCALER_W'(acc_c) : cnt_c_q + SCALER_W'(acc_c & ~(&cnt_c_q));
      out_l_q <= bus.SCALER_SNAP ? cnt_l_q : out_l_q;
      out_r_q <= bus.SCALER_SNAP ? cnt_r_q : out_r_q;
      out_c_q <= bus.SCALER_SNAP ? cnt_c_q : out_c_q;
    end
  end
  assign bus.L1_TRIG      = trig_q;
  assign bus.L1_POL       = pol_q;
  assign bus.LATCH_CLR_L  = clr_l_q;
  assign bus.LATCH_CLR_R  = clr_r_q;
  assign bus.SCALER_L     = out_l_q;
  assign bus.SCALER_R     = out_r_q;
  assign bus.SCALER_COINC = out_c_q;
endmodule

// File: doc/anita4_l1_coinc.md
# anita4_l1_coinc

Per-phi-sector L1 coincidence stage for ANITA4, directly downstream of the two single-polarization trigger synchronizers (LCP and RCP). Consumes each synchronizer's 3-bit shift output, detects new single-pol events, and fires a one-cycle L1 trigger when both polarizations fire within a programmable window. Drives the synchronizers' clear inputs to re-arm their latches after every decision, and keeps per-interval saturating scalers.

## Interface
Parameters:
- HOLDOFF, 4, cycles LATCH_CLR_L/R are held high after each decision; legal range 2..15.
- SCALER_W, 16, scaler width.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- CLR_B  in  1  reset, asynchronous, active-low.
- LCP_SYNC  in  3  LCP synchronizer shift output; bit 0 is metastable and unused.
- RCP_SYNC  in  3  RCP synchronizer shift output.
- MASK_L, MASK_R  in  1 each  1 = polarization disabled.
- WINDOW  in  4  coincidence window in cycles; sampled only on the IDLE->WAIT transition.
- SCALER_SNAP  in  1  one-cycle strobe that transfers counters to the outputs and restarts the interval.
- L1_TRIG  out  1  one-cycle coincidence pulse.
- L1_POL  out  2  first polarization of the last coincidence: 01 = L, 10 = R, 11 = simultaneous. Held until the next FIRE.
- LATCH_CLR_L, LATCH_CLR_R  out  1 each  active-high clear to the upstream synchronizer.
- SCALER_L, SCALER_R, SCALER_COINC  out  SCALER_W each  snapshot counts.

## Operation
- New-event detect:
  - new_L = LCP_SYNC[1] & ~LCP_SYNC[2] & ~MASK_L.
  - new_R = RCP_SYNC[1] & ~RCP_SYNC[2] & ~MASK_R.
  - Both are combinational.
- FSM states are IDLE, WAIT, FIRE and CLEAR. A registered counter cnt (4 bits) is used in WAIT and CLEAR.
- IDLE:
  - new_L & new_R -> FIRE with L1_POL = 11.
  - Exactly one new event and WINDOW != 0 -> WAIT. cnt loads WINDOW and the first polarization is recorded.
  - Exactly one new event and WINDOW == 0 -> CLEAR.
- WAIT:
  - The opposite polarization's new event -> FIRE with L1_POL = first polarization.
  - Otherwise, cnt == 1 -> CLEAR (timeout).
  - Otherwise cnt decrements.
  - Further events on the first polarization are ignored and not counted.
- FIRE: L1_TRIG = 1 for this one cycle -> CLEAR with cnt = HOLDOFF.
- CLEAR:
  - LATCH_CLR_L and LATCH_CLR_R = 1.
  - cnt decrements each cycle; cnt == 1 -> IDLE.
  - All new events are ignored.
- When MASK_x = 1, LATCH_CLR_x = 1 in every state, so a masked latch is held clear.
- Scalers:
  - SCALER_L counts new_L accepted in IDLE or WAIT; SCALER_R likewise for new_R.
  - The coincidence counter increments on FIRE.
  - Counters saturate at all-ones and never wrap.
- SCALER_SNAP:
  - Outputs load the current counts.
  - Counters restart at 0, or at 1 if an increment occurs in the same cycle (that event belongs to the new interval).
- Reset (CLR_B = 0):
  - FSM goes to IDLE and cnt = 0.
  - L1_TRIG = 0 and L1_POL = 00.
  - All counters and scaler outputs = 0.
  - LATCH_CLR_L and LATCH_CLR_R = 1, so the upstream stays clear.
  - Reset mid-WAIT or mid-CLEAR abandons the decision without firing.
- After reset release:
  - LATCH_CLR_x drops to 0 on the first CLK edge, unless MASK_x = 1.
  - FSM is in IDLE and events are accepted from that edge.

## Timing
- Outputs L1_TRIG, L1_POL, LATCH_CLR_L, LATCH_CLR_R and all scalers are registered.
- Simultaneous events (edge cycle n): L1_TRIG is high in cycle n+1 only.
- First event in cycle n with WINDOW = W:
  - The opposite polarization is checked in cycles n+1..n+W.
  - A hit in cycle n+k gives L1_TRIG in cycle n+k+1.
  - No hit gives CLEAR from cycle n+W+1.
- LATCH_CLR_L/R are high for exactly HOLDOFF cycles after FIRE, or after a timeout or WINDOW = 0 single.
  - Because the upstream clears its shift register synchronously, SYNC[2:1] = 00 on return to IDLE. Re-armed edges are therefore detected cleanly.
- Decision cycle:
  - Minimum, coincidence: 1 (FIRE) + HOLDOFF cycles.
  - Worst case: W + 1 + HOLDOFF cycles.
- WINDOW changes during WAIT have no effect until the next IDLE->WAIT transition.

## Test plan
- Reset behaviour: CLR_B low for 3 cycles, then released -> all outputs 0 and LATCH_CLR_L/R = 1 during reset; LATCH_CLR_L/R = 0 from the first edge after release.
- Simultaneous: WINDOW = 4, L and R SYNC[1] both rise in cycle 10 -> L1_TRIG high in cycle 11 only, L1_POL = 11, LATCH_CLR_L/R high in cycles 12..15 (HOLDOFF = 4), SCALER_COINC = 1 after a snap.
- Window edges: WINDOW = 3, L in cycle 10 and R in cycle 13 -> fire in cycle 14 with L1_POL = 01. Repeat with R in cycle 14 -> no L1_TRIG and CLEAR from cycle 14; SCALER_L = 1 and SCALER_R = 0.
- Masking: MASK_R = 1, L and R events -> LATCH_CLR_R stays 1, no L1_TRIG, SCALER_R = 0. WINDOW = 0 with an L-only event -> CLEAR the next cycle, no trigger.
- Scaler saturation and snap: SCALER_W = 4, 20 L events -> SCALER_L = 15 at snap. An event in the snap cycle -> that snap shows the old count and the next snap includes the event (restart value 1).
- Reset mid-WAIT: L event, then CLR_B low 2 cycles later, then R event after release -> no L1_TRIG; FSM back in IDLE, and the R event starts a fresh WAIT.
